// File: rtl/rvv_trap_drain.sv
// Vector-unit trap drain controller: stalls the command queue, waits for the pipeline
// to go quiet, handshakes the trap with the scalar core and offers a vcsr snapshot.
module rvv_trap_drain #(
  parameter int unsigned ISSUE_LANE    = 2,
  parameter int unsigned VCSR_W        = 32,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_valid_rvs2rvv,
  output logic                  trap_ready_rvv2rvs,
  input  logic [ISSUE_LANE-1:0] cmdq_push,
  input  logic                  cmd_q_empty,
  input  logic                  uop_q_empty,
  input  logic                  alu_rs_empty,
  input  logic                  mul_rs_empty,
  input  logic                  div_rs_empty,
  input  logic                  pmtrdt_rs_empty,
  input  logic                  lsu_rs_empty,
  input  logic                  rob_empty,
  input  logic                  vrf_wr_busy,
  input  logic                  rt_vcsr_valid,
  input  logic [VCSR_W-1:0]     rt_vcsr_data,
  output logic                  vcsr_valid,
  output logic [VCSR_W-1:0]     vcsr_data,
  input  logic                  vcsr_ready,
  output logic                  cmdq_stall,
  output logic                  rvv_idle,
  output logic                  drain_err
);

  typedef enum logic [2:0] {StIdle, StDrain, StAck, StVcsr, StRelease} state_e;

  localparam logic [15:0] TimeoutVal = 16'(DRAIN_TIMEOUT);

  state_e              state_q, state_d;
  logic [1:0]          empty_cnt_q, empty_cnt_d;
  logic [15:0]         drain_cnt_q, drain_cnt_d;
  logic [VCSR_W-1:0]   last_vcsr_q, vcsr_data_q;
  logic                trap_ready_q, vcsr_valid_q, cmdq_stall_q, drain_err_q, rvv_idle_q;
  logic                drain_err_d;
  logic                pipe_empty;

  assign pipe_empty = cmd_q_empty & uop_q_empty & alu_rs_empty & mul_rs_empty &
                      div_rs_empty & pmtrdt_rs_empty & lsu_rs_empty & rob_empty &
                      (cmdq_push == '0) & ~vrf_wr_busy;

  always_comb begin
    state_d     = state_q;
    empty_cnt_d = empty_cnt_q;
    drain_cnt_d = drain_cnt_q;
    drain_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trap_valid_rvs2rvv) begin
          state_d     = StDrain;
          empty_cnt_d = 2'd0;
          drain_cnt_d = 16'd0;
        end
      end
      StDrain: begin
        empty_cnt_d = pipe_empty ? empty_cnt_q + 2'd1 : 2'd0;
        // Saturate so the timeout pulse can never fire a second time.
        if (drain_cnt_q != 16'hFFFF) begin
          drain_cnt_d = drain_cnt_q + 16'd1;
          drain_err_d = (drain_cnt_d == TimeoutVal);
        end
        if (!trap_valid_rvs2rvv) begin
          state_d = StIdle;
        end else if (empty_cnt_d == 2'd2) begin
          state_d = StAck;
        end
      end
      StAck:     state_d = StVcsr;
      StVcsr:    if (vcsr_ready) state_d = StRelease;
      StRelease: if (!trap_valid_rvs2rvv) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      empty_cnt_q  <= 2'd0;
      drain_cnt_q  <= 16'd0;
      last_vcsr_q  <= '0;
      vcsr_data_q  <= '0;
      trap_ready_q <= 1'b0;
      vcsr_valid_q <= 1'b0;
      cmdq_stall_q <= 1'b0;
      drain_err_q  <= 1'b0;
      rvv_idle_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      empty_cnt_q  <= empty_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      trap_ready_q <= (state_d == StAck);
      vcsr_valid_q <= (state_d == StVcsr);
      cmdq_stall_q <= (state_d != StIdle);
      drain_err_q  <= drain_err_d;
      rvv_idle_q   <= pipe_empty & (state_q == StIdle) & ~trap_valid_rvs2rvv & ~vcsr_ready;
      if (rt_vcsr_valid) begin
        last_vcsr_q <= rt_vcsr_data;
      end
      // Snapshot is taken from the register, so a same-cycle retire update is not included.
      if (state_q == StDrain && state_d == StAck) begin
        vcsr_data_q <= last_vcsr_q;
      end
    end
  end

  assign trap_ready_rvv2rvs = trap_ready_q;
  assign vcsr_valid         = vcsr_valid_q;
  assign vcsr_data          = vcsr_data_q;
  assign cmdq_stall         = cmdq_stall_q;
  assign drain_err          = drain_err_q;
  assign rvv_idle           = rvv_idle_q;

endmodule

// File: tb/tb_rvv_trap_drain.sv
// Directed and randomized bench for rvv_trap_drain against a transaction-level model.
module tb_rvv_trap_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [1:0]  cmdq_push;
  logic [7:0]  empties;
  logic        vrf_wr_busy;
  logic        rt_vcsr_valid;
  logic [31:0] rt_vcsr_data;
  logic        vcsr_ready;

  logic        trap_ready, vcsr_valid, cmdq_stall, rvv_idle, drain_err;
  logic [31:0] vcsr_data;
  logic        t_trap_ready, t_vcsr_valid, t_cmdq_stall, t_rvv_idle, t_drain_err;
  logic [31:0] t_vcsr_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_last = '0;

  always #5 clk = ~clk;

  rvv_trap_drain #(.ISSUE_LANE(2), .VCSR_W(32)) dut (
    .clk(clk), .rst(rst), .trap_valid_rvs2rvv(trap_valid), .trap_ready_rvv2rvs(trap_ready),
    .cmdq_push(cmdq_push), .cmd_q_empty(empties[0]), .uop_q_empty(empties[1]),
    .alu_rs_empty(empties[2]), .mul_rs_empty(empties[3]), .div_rs_empty(empties[4]),
    .pmtrdt_rs_empty(empties[5]), .lsu_rs_empty(empties[6]), .rob_empty(empties[7]),
    .vrf_wr_busy(vrf_wr_busy), .rt_vcsr_valid(rt_vcsr_valid), .rt_vcsr_data(rt_vcsr_data),
    .vcsr_valid(vcsr_valid), .vcsr_data(vcsr_data), .vcsr_ready(vcsr_ready),
    .cmdq_stall(cmdq_stall), .rvv_idle(rvv_idle), .drain_err(drain_err)
  );

  rvv_trap_drain #(.ISSUE_LANE(2), .VCSR_W(32), .DRAIN_TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .trap_valid_rvs2rvv(trap_valid), .trap_ready_rvv2rvs(t_trap_ready),
    .cmdq_push(cmdq_push), .cmd_q_empty(empties[0]), .uop_q_empty(empties[1]),
    .alu_rs_empty(empties[2]), .mul_rs_empty(empties[3]), .div_rs_empty(empties[4]),
    .pmtrdt_rs_empty(empties[5]), .lsu_rs_empty(empties[6]), .rob_empty(empties[7]),
    .vrf_wr_busy(vrf_wr_busy), .rt_vcsr_valid(rt_vcsr_valid), .rt_vcsr_data(rt_vcsr_data),
    .vcsr_valid(t_vcsr_valid), .vcsr_data(t_vcsr_data), .vcsr_ready(vcsr_ready),
    .cmdq_stall(t_cmdq_stall), .rvv_idle(t_rvv_idle), .drain_err(t_drain_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit rdy, input bit vv, input bit st,
                          input bit er);
    chk({tag, ".trap_ready"}, 32'(trap_ready), 32'(rdy));
    chk({tag, ".vcsr_valid"}, 32'(vcsr_valid), 32'(vv));
    chk({tag, ".cmdq_stall"}, 32'(cmdq_stall), 32'(st));
    chk({tag, ".drain_err"}, 32'(drain_err), 32'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply retire updates the DUT just sampled to the model's last-vcsr value.
  task automatic commit_rt();
    if (rt_vcsr_valid) model_last = rt_vcsr_data;
  endtask

  task automatic drive_rt(input int pct);
    rt_vcsr_valid = ($urandom_range(0, 99) < pct);
    rt_vcsr_data  = $urandom;
  endtask

  task automatic set_pipe(input bit e);
    int r;
    empties     = 8'hFF;
    cmdq_push   = 2'b00;
    vrf_wr_busy = 1'b0;
    if (!e) begin
      r = $urandom_range(0, 9);
      if (r < 8) empties[r] = 1'b0;
      else if (r == 8) cmdq_push = 2'($urandom_range(1, 3));
      else vrf_wr_busy = 1'b1;
    end
  endtask

  function automatic bit pipe_now();
    return (&empties) && (cmdq_push == 2'b00) && !vrf_wr_busy;
  endfunction

  // One full trap transaction. rob_low >= 0 gives a directed drain with rob_empty low for
  // that many drain cycles; otherwise the drain pattern is random.
  task automatic run_trap(input int rob_low, input int rt_pct, input int rdly, input bit a5);
    logic [31:0] snap;
    bit          prev, e, hold;
    int          ack_k;
    snap  = '0;
    ack_k = -1;
    trap_valid = 1'b1;
    vcsr_ready = 1'b0;
    set_pipe(1'b1);
    if (a5) rt_vcsr_valid = 1'b0; else drive_rt(rt_pct);
    tick();
    commit_rt();
    chk_outs("drain_entry", 0, 0, 1, 0);
    chk("idle_with_trap", 32'(rvv_idle), 32'd0);
    prev = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (rob_low >= 0) begin
        set_pipe(1'b1);
        if (k < rob_low) empties[7] = 1'b0;
      end else begin
        set_pipe((k >= 24) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      if (a5) begin
        rt_vcsr_valid = (k == 3);
        rt_vcsr_data  = 32'h0000_00A5;
      end else begin
        drive_rt(rt_pct);
      end
      e = pipe_now();
      tick();
      if (prev && e) begin
        snap = model_last;
        commit_rt();
        ack_k = k;
        break;
      end
      commit_rt();
      chk_outs("drain", 0, 0, 1, 0);
      prev = e;
    end
    if (rob_low >= 0) chk("ack_latency", 32'(ack_k), 32'(rob_low + 1));
    chk_outs("ack", 1, 0, 1, 0);
    hold = 1'($urandom_range(0, 1));
    trap_valid = hold;
    set_pipe(1'($urandom_range(0, 1)));
    drive_rt(rt_pct);
    tick();
    commit_rt();
    chk_outs("vcsr", 0, 1, 1, 0);
    chk("vcsr_data", vcsr_data, snap);
    if (a5) chk("vcsr_data_a5", vcsr_data, 32'h0000_00A5);
    for (int d = 0; d < rdly; d++) begin
      drive_rt((d == 2) ? 100 : rt_pct);
      tick();
      commit_rt();
      chk_outs("vcsr_hold", 0, 1, 1, 0);
      chk("vcsr_data_hold", vcsr_data, snap);
    end
    vcsr_ready = 1'b1;
    drive_rt(rt_pct);
    tick();
    commit_rt();
    chk_outs("release", 0, 0, 1, 0);
    vcsr_ready = 1'b0;
    if (hold) begin
      for (int h = 0; h < 2; h++) begin
        tick();
        commit_rt();
        chk_outs("release_hold", 0, 0, 1, 0);
      end
    end
    trap_valid = 1'b0;
    tick();
    commit_rt();
    chk_outs("back_idle", 0, 0, 0, 0);
    set_pipe(1'b1);
    rt_vcsr_valid = 1'b0;
    tick();
    chk("idle_after_trap", 32'(rvv_idle), 32'd1);
  endtask

  initial begin
    bit exp_idle;
    rst = 1'b1;
    trap_valid = 1'b0;
    vcsr_ready = 1'b0;
    rt_vcsr_valid = 1'b0;
    rt_vcsr_data = '0;
    set_pipe(1'b1);
    tick();
    chk_outs("reset", 0, 0, 0, 0);
    chk("reset.vcsr_data", vcsr_data, 32'd0);
    chk("reset.rvv_idle", 32'(rvv_idle), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'(rvv_idle), 32'd1);

    // Idle indication under random structure activity and stray vcsr_ready.
    for (int i = 0; i < 24; i++) begin
      for (int b = 0; b < 8; b++) empties[b] = ($urandom_range(0, 7) != 0);
      cmdq_push   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      vrf_wr_busy = ($urandom_range(0, 5) == 0);
      vcsr_ready  = ($urandom_range(0, 3) == 0);
      exp_idle    = pipe_now() && !vcsr_ready;
      tick();
      chk("idle_model", 32'(rvv_idle), 32'(exp_idle));
      chk_outs("idle_quiet", 0, 0, 0, 0);
    end
    vcsr_ready = 1'b0;
    set_pipe(1'b1);
    tick();

    run_trap(0, 0, 0, 0);
    run_trap(10, 0, 1, 1);
    run_trap(-1, 50, 5, 0);
    for (int i = 0; i < 8; i++) run_trap(-1, 30, $urandom_range(0, 3), 0);

    // Trap withdrawn mid-drain.
    for (int i = 0; i < 3; i++) begin
      trap_valid = 1'b1;
      set_pipe(1'b0);
      tick();
      chk_outs("wd_entry", 0, 0, 1, 0);
      for (int n = 0; n < i * 2; n++) begin
        set_pipe(1'b0);
        tick();
        chk_outs("wd_drain", 0, 0, 1, 0);
      end
      trap_valid = 1'b0;
      set_pipe(1'b0);
      tick();
      chk_outs("wd_idle", 0, 0, 0, 0);
      set_pipe(1'b1);
      for (int n = 0; n < 3; n++) begin
        tick();
        chk_outs("wd_after", 0, 0, 0, 0);
      end
    end

    // Drain never completes: 8-cycle and default timeouts each pulse once.
    trap_valid = 1'b1;
    set_pipe(1'b0);
    tick();
    for (int c = 1; c <= 260; c++) begin
      chk("tmo8.drain_err", 32'(t_drain_err), 32'(c == 9));
      chk_outs("tmo_default", 0, 0, 1, c == 256);
      chk("tmo8.trap_ready", 32'(t_trap_ready), 32'd0);
      set_pipe(1'b0);
      tick();
    end
    trap_valid = 1'b0;
    tick();
    chk_outs("tmo_abandon", 0, 0, 0, 0);
    set_pipe(1'b1);
    tick();

    // Reset in the middle of the vcsr handshake.
    trap_valid = 1'b1;
    rt_vcsr_valid = 1'b1;
    rt_vcsr_data = 32'hDEAD_BEEF;
    tick();
    rt_vcsr_valid = 1'b0;
    tick();
    tick();
    chk_outs("pre_rst_ack", 1, 0, 1, 0);
    trap_valid = 1'b0;
    tick();
    chk_outs("pre_rst_vcsr", 0, 1, 1, 0);
    chk("pre_rst_data", vcsr_data, 32'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    chk_outs("mid_rst", 0, 0, 0, 0);
    chk("mid_rst.vcsr_data", vcsr_data, 32'd0);
    chk("mid_rst.rvv_idle", 32'(rvv_idle), 32'd0);
    model_last = '0;
    rst = 1'b0;
    tick();
    chk_outs("after_rst", 0, 0, 0, 0);
    chk("after_rst.rvv_idle", 32'(rvv_idle), 32'd1);
    tick();
    chk_outs("after_rst2", 0, 0, 0, 0);
    run_trap(-1, 0, 2, 0);
    run_trap(-1, 40, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvv_trap_drain.md
RVV_TRAP_DRAIN -- requirements
Module: rvv_trap_drain

Interface
REQ-001 SHALL have parameter ISSUE_LANE, default 2: number of command-queue issue lanes.
REQ-002 SHALL have parameter VCSR_W, default 32: width of the vcsr snapshot.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 255: drain cycles before drain_err pulses; legal range 2..65535.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: clock; all state samples on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port trap_valid_rvs2rvv, input, 1: scalar core requests a trap; held high until trap_ready_rvv2rvs is seen.
REQ-008 SHALL have port trap_ready_rvv2rvs, output, 1: RVV is drained and accepts the trap.
REQ-009 SHALL have port cmdq_push, input, ISSUE_LANE: per-lane command-queue push strobes.
REQ-010 SHALL have ports cmd_q_empty, uop_q_empty, alu_rs_empty, mul_rs_empty, div_rs_empty, pmtrdt_rs_empty, lsu_rs_empty and rob_empty, each input, 1: structure-empty flags.
REQ-011 SHALL have port vrf_wr_busy, input, 1: OR of all pending VRF write enables.
REQ-012 SHALL have port rt_vcsr_valid, input, 1: the retire stage updates the architectural vcsr this cycle.
REQ-013 SHALL have port rt_vcsr_data, input, VCSR_W: vcsr value of the retiring uop.
REQ-014 SHALL have port vcsr_valid, output, 1: vcsr snapshot offered to the scalar core.
REQ-015 SHALL have port vcsr_data, output, VCSR_W: vcsr snapshot.
REQ-016 SHALL have port vcsr_ready, input, 1: scalar core accepts the snapshot.
REQ-017 SHALL have port cmdq_stall, output, 1: blocks new command-queue pushes.
REQ-018 SHALL have port rvv_idle, output, 1: registered whole-unit idle indication.
REQ-019 SHALL have port drain_err, output, 1: one-cycle pulse on drain timeout.

Function
REQ-020 SHALL define pipe_empty (combinational) = all eight empty flags high, cmdq_push all zero, and vrf_wr_busy low.
REQ-021 SHALL implement the FSM states IDLE, DRAIN, ACK, VCSR and RELEASE.
REQ-022 SHALL transition IDLE->DRAIN on the cycle after trap_valid_rvs2rvv is sampled high.
REQ-023 SHALL drive cmdq_stall high in every state except IDLE, as a registered output.
REQ-024 SHALL, in DRAIN, count consecutive cycles with pipe_empty high, resetting the count to 0 on any cycle pipe_empty is low.
REQ-025 SHALL transition DRAIN->ACK when the consecutive count reaches 2, so a push launched in the stall-assertion cycle is absorbed.
REQ-026 SHALL transition DRAIN->IDLE, releasing cmdq_stall, if trap_valid_rvs2rvv drops while in DRAIN.
REQ-027 SHALL keep a 16-bit saturating DRAIN cycle counter, cleared on DRAIN entry.
REQ-028 SHALL pulse drain_err for exactly one cycle when that counter equals DRAIN_TIMEOUT, and SHALL remain in DRAIN afterwards.
REQ-029 SHALL assert trap_ready_rvv2rvs for exactly one cycle while in ACK, then transition ACK->VCSR.
REQ-030 SHALL maintain a last_vcsr register loaded with rt_vcsr_data on every cycle rt_vcsr_valid is high, in any state.
REQ-031 SHALL capture last_vcsr into vcsr_data on ACK entry and hold it stable while vcsr_valid is high.
REQ-032 SHALL assert vcsr_valid in VCSR and hold it, with vcsr_data unchanged, until vcsr_ready is sampled high; vcsr_valid SHALL deassert on the following cycle.
REQ-033 SHALL transition VCSR->RELEASE on the vcsr handshake.
REQ-034 SHALL transition RELEASE->IDLE once trap_valid_rvs2rvv is low; cmdq_stall SHALL drop in that same IDLE cycle.
REQ-035 SHALL ignore vcsr_ready outside VCSR.
REQ-036 SHALL ignore trap_valid_rvs2rvv in ACK and VCSR.
REQ-037 SHALL drive rvv_idle, registered, as pipe_empty AND state==IDLE AND NOT trap_valid_rvs2rvv AND NOT vcsr_ready.

Reset
REQ-038 SHALL, while rst is high, force state to IDLE; trap_ready_rvv2rvs, vcsr_valid, cmdq_stall, drain_err and rvv_idle to 0; and vcsr_data, last_vcsr and all counters to 0.
REQ-039 SHALL abandon any in-flight handshake on reset asserted mid-operation, with no residual pulse after reset deasserts.
REQ-040 SHALL evaluate rvv_idle normally from the first cycle after reset.

Verification
REQ-041 Scenario: pipeline already empty, trap_valid high at cycle 0 -> cmdq_stall=1 at cycle 1; trap_ready one cycle at cycle 3; vcsr_valid from cycle 4.
REQ-042 Scenario: rob_empty low for 10 cycles after the trap, with rt_vcsr_valid data 0x0000_00A5 during the drain -> trap_ready only after 2 empty cycles; vcsr_data=0x0000_00A5.
REQ-043 Scenario: DRAIN_TIMEOUT=8 with pipeline never empty -> drain_err high exactly once, 8 cycles after DRAIN entry; no trap_ready.
REQ-044 Scenario: trap_valid dropped in DRAIN -> IDLE next cycle, cmdq_stall=0, no trap_ready, no vcsr_valid.
REQ-045 Scenario: vcsr_ready held low for 5 cycles -> vcsr_valid and vcsr_data stable for those 5 cycles, even with an rt_vcsr_valid update arriving meanwhile.
REQ-046 Scenario: rst pulsed during VCSR -> all outputs 0 the next cycle; a fresh trap then completes normally.
